// File: rtl/imm_field_encoder_pkg.sv
// Shared constants for immediate classes, error codes and field placement.
// The sign-extend path decodes with these same values.
package imm_field_encoder_pkg;

   localparam logic [1:0] IMM_I  = 2'd0;
   localparam logic [1:0] IMM_D  = 2'd1;
   localparam logic [1:0] IMM_B  = 2'd2;
   localparam logic [1:0] IMM_CB = 2'd3;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_RANGE = 2'd1;
   localparam logic [1:0] ERR_ALIGN = 2'd2;

   // Field LSB in the instruction word and field width per class.
   // B and CB carry a word offset, so their source bits start at imm[2].
   localparam int unsigned I_LSB  = 10;
   localparam int unsigned I_W    = 12;
   localparam int unsigned D_LSB  = 12;
   localparam int unsigned D_W    = 9;
   localparam int unsigned B_LSB  = 0;
   localparam int unsigned B_W    = 26;
   localparam int unsigned CB_LSB = 5;
   localparam int unsigned CB_W   = 19;

   function automatic logic [31:0] field_mask(input int unsigned lsb, input int unsigned w);
      logic [31:0] ones;
      ones = (32'd1 << w) - 32'd1;
      return ones << lsb;
   endfunction

endpackage

// File: rtl/imm_field_encoder_pack.sv
// Combinational immediate packer: clears the class field of the base word,
// inserts the immediate and reports range/alignment violations.
module imm_field_pack
   import imm_field_encoder_pkg::*;
(
   input  logic [1:0]  imm_class,
   input  logic [63:0] imm,
   input  logic [31:0] base,
   output logic [31:0] inst,
   output logic [1:0]  err
);

   logic [31:0] mask;
   logic [31:0] field;

   always_comb begin
      mask  = '0;
      field = '0;
      err   = ERR_NONE;
      case (imm_class)
         IMM_I: begin
            mask  = field_mask(I_LSB, I_W);
            field = 32'(imm[I_W-1:0]) << I_LSB;
            if (|imm[63:I_W]) err = ERR_RANGE;
         end
         IMM_D: begin
            mask  = field_mask(D_LSB, D_W);
            field = 32'(imm[D_W-1:0]) << D_LSB;
            if (|imm[63:D_W]) err = ERR_RANGE;
         end
         IMM_B: begin
            mask  = field_mask(B_LSB, B_W);
            field = 32'(imm[B_W+1:2]) << B_LSB;
            // Alignment is checked last so it overrides a range error.
            if (imm[63:B_W+1] != {(64-B_W-1){imm[B_W+1]}}) err = ERR_RANGE;
            if (|imm[1:0]) err = ERR_ALIGN;
         end
         default: begin
            mask  = field_mask(CB_LSB, CB_W);
            field = 32'(imm[CB_W+1:2]) << CB_LSB;
            if (imm[63:CB_W+1] != {(64-CB_W-1){imm[CB_W+1]}}) err = ERR_RANGE;
            if (|imm[1:0]) err = ERR_ALIGN;
         end
      endcase
      inst = (base & ~mask) | ((err == ERR_NONE) ? (field & mask) : 32'd0);
   end

endmodule

// File: rtl/imm_field_encoder.sv
// Streaming immediate encoder: packer, output register with skid buffer
// for full throughput, and a saturating error counter.
module imm_field_encoder
   import imm_field_encoder_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [1:0]       i_class,
   input  logic [63:0]      i_imm,
   input  logic [31:0]      i_base,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [31:0]      o_inst,
   output logic [1:0]       o_err,
   input  logic             i_clr_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);

   logic [31:0] pack_inst;
   logic [1:0]  pack_err;
   logic        skid_valid;
   logic [31:0] skid_inst;
   logic [1:0]  skid_err;
   logic        accept;
   logic        take;

   imm_field_pack u_pack (
      .imm_class (i_class),
      .imm       (i_imm),
      .base      (i_base),
      .inst      (pack_inst),
      .err       (pack_err)
   );

   assign o_ready = !skid_valid;
   assign accept  = i_valid && o_ready;
   assign take    = o_valid && i_ready;

   // A full skid implies o_ready is low, so accept and skid drain never coincide.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid    <= 1'b0;
         o_inst     <= '0;
         o_err      <= ERR_NONE;
         skid_valid <= 1'b0;
         skid_inst  <= '0;
         skid_err   <= ERR_NONE;
      end else if (skid_valid) begin
         if (take) begin
            o_inst     <= skid_inst;
            o_err      <= skid_err;
            skid_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!o_valid || take) begin
            o_valid <= 1'b1;
            o_inst  <= pack_inst;
            o_err   <= pack_err;
         end else begin
            skid_valid <= 1'b1;
            skid_inst  <= pack_inst;
            skid_err   <= pack_err;
         end
      end else if (take) begin
         o_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_err_cnt <= '0;
      end else if (i_clr_cnt) begin
         o_err_cnt <= '0;
      end else if (accept && (pack_err != ERR_NONE) && (o_err_cnt != '1)) begin
         o_err_cnt <= o_err_cnt + 1'b1;
      end
   end

endmodule
